// File: rtl/mesh_hs_pkg.sv
// Shared types and helpers for the mesh pending/pop handshake checker.
package mesh_hs_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StLate = 2'd2
    } hs_state_e;

    // Bit positions inside a channel's error strobe vector.
    typedef enum logic [1:0] {
        ErrPop      = 2'd0,
        ErrTimeout  = 2'd1,
        ErrWithdraw = 2'd2,
        ErrData     = 2'd3
    } err_type_e;

    localparam int unsigned NumErr = 4;

    // Latency counter width: must hold MAX_LAT+1, the saturated late latency.
    function automatic int unsigned lat_w(input int unsigned max_lat);
        return $clog2(max_lat + 2);
    endfunction

endpackage

// File: rtl/mesh_hs_chk_ch.sv
// One channel of the handshake checker: protocol FSM, latency counter,
// captured payload, and single-cycle error / completion strobes.
module mesh_hs_chk_ch
    import mesh_hs_pkg::*;
#(
    parameter int unsigned DATA_W  = 40,
    parameter int unsigned MAX_LAT = 100,
    parameter int unsigned LAT_W   = 7
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              pndng_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [NumErr-1:0] err_o,
    output logic              done_o,
    output logic [LAT_W-1:0]  done_lat_o
);

    localparam logic [LAT_W-1:0] MaxLat  = LAT_W'(MAX_LAT);
    localparam logic [LAT_W-1:0] LateLat = LAT_W'(MAX_LAT + 1);

    hs_state_e         state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic              pndng_q;

    // State register plus the latency counter, captured data and previous pndng.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            lat_q   <= '0;
            cap_q   <= '0;
            pndng_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            cap_q   <= cap_d;
            pndng_q <= pndng_i;
        end
    end

    // Next-state logic; lat tracks the cycle index since the request started.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        cap_d   = cap_q;
        unique case (state_q)
            StIdle: begin
                if (pndng_i && !pop_i) begin
                    state_d = StWait;
                    lat_d   = LAT_W'(1);
                    cap_d   = data_i;
                end
            end
            StWait: begin
                if (pop_i || !pndng_i) begin
                    state_d = StIdle;
                    lat_d   = '0;
                end else if (lat_q == MaxLat) begin
                    state_d = StLate;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            StLate: begin
                if (pop_i || !pndng_i) begin
                    state_d = StIdle;
                    lat_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                lat_d   = '0;
            end
        endcase
    end

    // Output strobes: errors and completion for the current sample.
    always_comb begin
        err_o      = '0;
        done_o     = 1'b0;
        done_lat_o = '0;
        unique case (state_q)
            StIdle: begin
                if (pndng_i && pop_i) begin
                    done_o = 1'b1;
                end else if (!pndng_i && pop_i && !pndng_q) begin
                    // A pop right after pndng fell is a legal trailing pop.
                    err_o[ErrPop] = 1'b1;
                end
            end
            StWait: begin
                if (pop_i) begin
                    done_o     = 1'b1;
                    done_lat_o = lat_q;
                end else if (!pndng_i) begin
                    err_o[ErrWithdraw] = 1'b1;
                end else if (lat_q == MaxLat) begin
                    err_o[ErrTimeout] = 1'b1;
                end
                if (pndng_i && (data_i != cap_q)) err_o[ErrData] = 1'b1;
            end
            StLate: begin
                if (pop_i) begin
                    done_o     = 1'b1;
                    done_lat_o = LateLat;
                end
                if (pndng_i && (data_i != cap_q)) err_o[ErrData] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mesh_hs_checker.sv
// Multi-channel pending/pop handshake checker: sticky error flags,
// saturating transaction counters and global worst-case latency.
module mesh_hs_checker
    import mesh_hs_pkg::*;
#(
    parameter int unsigned NUM_CH  = 16,
    parameter int unsigned DATA_W  = 40,
    parameter int unsigned MAX_LAT = 100,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned LatW   = lat_w(MAX_LAT),
    localparam int unsigned ChW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_CH-1:0]        pndng_i,
    input  logic [NUM_CH-1:0]        pop_i,
    input  logic [NUM_CH*DATA_W-1:0] data_i,
    input  logic                     clr_i,
    output logic [NUM_CH-1:0]        err_pop_o,
    output logic [NUM_CH-1:0]        err_timeout_o,
    output logic [NUM_CH-1:0]        err_withdraw_o,
    output logic [NUM_CH-1:0]        err_data_o,
    output logic                     err_any_o,
    output logic [NUM_CH*CNT_W-1:0]  txn_cnt_o,
    output logic [LatW-1:0]          max_lat_o,
    output logic [ChW-1:0]           max_lat_ch_o
);

    logic [NumErr-1:0] ch_err [NUM_CH];
    logic [LatW-1:0]   ch_lat [NUM_CH];
    logic [NUM_CH-1:0] ch_done;
    logic [NUM_CH-1:0] stb_pop, stb_to, stb_wd, stb_data;

    logic [NUM_CH-1:0] pop_q, pop_d, to_q, to_d, wd_q, wd_d, data_q, data_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [LatW-1:0]   max_q, max_d;
    logic [ChW-1:0]    mch_q, mch_d;
    logic              any_q;

    logic              best_vld;
    logic [LatW-1:0]   best_lat;
    logic [ChW-1:0]    best_ch;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mesh_hs_chk_ch #(
            .DATA_W  (DATA_W),
            .MAX_LAT (MAX_LAT),
            .LAT_W   (LatW)
        ) u_ch (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .pndng_i    (pndng_i[i]),
            .pop_i      (pop_i[i]),
            .data_i     (data_i[i*DATA_W +: DATA_W]),
            .err_o      (ch_err[i]),
            .done_o     (ch_done[i]),
            .done_lat_o (ch_lat[i])
        );
        assign stb_pop[i]  = ch_err[i][ErrPop];
        assign stb_to[i]   = ch_err[i][ErrTimeout];
        assign stb_wd[i]   = ch_err[i][ErrWithdraw];
        assign stb_data[i] = ch_err[i][ErrData];
        assign txn_cnt_o[i*CNT_W +: CNT_W] = cnt_q[i];
    end

    // Pick the largest completed latency this cycle; strict > keeps the lowest index on ties.
    always_comb begin
        best_vld = 1'b0;
        best_lat = '0;
        best_ch  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_done[i] && (!best_vld || (ch_lat[i] > best_lat))) begin
                best_vld = 1'b1;
                best_lat = ch_lat[i];
                best_ch  = ChW'(i);
            end
        end
    end

    // Sticky/counter next state; new events are applied on top of clr so they survive it.
    always_comb begin
        pop_d  = (clr_i ? '0 : pop_q)  | stb_pop;
        to_d   = (clr_i ? '0 : to_q)   | stb_to;
        wd_d   = (clr_i ? '0 : wd_q)   | stb_wd;
        data_d = (clr_i ? '0 : data_q) | stb_data;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = clr_i ? '0 : cnt_q[i];
            if (ch_done[i] && (cnt_d[i] != '1)) cnt_d[i] = cnt_d[i] + CNT_W'(1);
        end
        max_d = clr_i ? '0 : max_q;
        mch_d = clr_i ? '0 : mch_q;
        if (best_vld && (clr_i || (best_lat > max_d))) begin
            max_d = best_lat;
            mch_d = best_ch;
        end
    end

    // Registered flags, counters, max latency and the lagging err_any summary.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pop_q  <= '0;
            to_q   <= '0;
            wd_q   <= '0;
            data_q <= '0;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
            max_q  <= '0;
            mch_q  <= '0;
            any_q  <= 1'b0;
        end else begin
            pop_q  <= pop_d;
            to_q   <= to_d;
            wd_q   <= wd_d;
            data_q <= data_d;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
            max_q  <= max_d;
            mch_q  <= mch_d;
            any_q  <= |{pop_q, to_q, wd_q, data_q};
        end
    end

    assign err_pop_o      = pop_q;
    assign err_timeout_o  = to_q;
    assign err_withdraw_o = wd_q;
    assign err_data_o     = data_q;
    assign err_any_o      = any_q;
    assign max_lat_o      = max_q;
    assign max_lat_ch_o   = mch_q;

endmodule

// File: tb/tb_mesh_hs_checker.sv
// Directed bench for mesh_hs_checker: a vector table plus hand-written
// timeout and reset sequences.
module tb_mesh_hs_checker;

    localparam int NCH  = 16;
    localparam int DW   = 40;
    localparam int MLAT = 100;
    localparam int CW   = 16;
    localparam int LW   = 7;
    localparam int CHW  = 4;

    logic              clk;
    logic              rst_n;
    logic [NCH-1:0]    pndng, pop;
    logic [DW-1:0]     dval;
    logic [NCH*DW-1:0] data;
    logic              clr;
    logic [NCH-1:0]    err_pop, err_to, err_wd, err_data;
    logic              err_any;
    logic [NCH*CW-1:0] txn_cnt;
    logic [LW-1:0]     max_lat;
    logic [CHW-1:0]    max_ch;

    int n_chk  = 0;
    int n_fail = 0;

    assign data = {NCH{dval}};

    mesh_hs_checker #(
        .NUM_CH  (NCH),
        .DATA_W  (DW),
        .MAX_LAT (MLAT),
        .CNT_W   (CW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .pndng_i        (pndng),
        .pop_i          (pop),
        .data_i         (data),
        .clr_i          (clr),
        .err_pop_o      (err_pop),
        .err_timeout_o  (err_to),
        .err_withdraw_o (err_wd),
        .err_data_o     (err_data),
        .err_any_o      (err_any),
        .txn_cnt_o      (txn_cnt),
        .max_lat_o      (max_lat),
        .max_lat_ch_o   (max_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pndng;
        logic [15:0] pop;
        logic [39:0] data;
        logic        clr;
        logic [15:0] epop;
        logic [15:0] eto;
        logic [15:0] ewd;
        logic [15:0] edata;
        logic [6:0]  emax;
        logic [3:0]  ech;
        int          cch;
        logic [15:0] ecnt;
        logic        eany;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [15:0] pn, input logic [15:0] po, input logic [39:0] d,
                       input logic c, input logic [15:0] epop, input logic [15:0] eto,
                       input logic [15:0] ewd, input logic [15:0] edat, input logic [6:0] emax,
                       input logic [3:0] ech, input int cch, input logic [15:0] ecnt,
                       input logic eany);
        vec_t v;
        v.pndng = pn;  v.pop = po;   v.data = d;    v.clr = c;
        v.epop = epop; v.eto = eto;  v.ewd = ewd;   v.edata = edat;
        v.emax = emax; v.ech = ech;  v.cch = cch;   v.ecnt = ecnt;  v.eany = eany;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] cnt_of(input int ch);
        return txn_cnt[ch*CW +: CW];
    endfunction

    // Called at a negedge: drive one sample, let the DUT clock it, return at the next negedge.
    task automatic step(input logic [15:0] pn, input logic [15:0] po, input logic [39:0] d,
                        input logic c);
        pndng = pn;
        pop   = po;
        dval  = d;
        clr   = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] pn, po;

        rst_n = 1'b0;
        pndng = '0;
        pop   = '0;
        dval  = 40'h12;
        clr   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst err_pop", err_pop, 0);
        chk("rst err_timeout", err_to, 0);
        chk("rst err_withdraw", err_wd, 0);
        chk("rst err_data", err_data, 0);
        chk("rst err_any", err_any, 0);
        chk("rst txn_cnt", txn_cnt, 0);
        chk("rst max_lat", max_lat, 0);
        chk("rst max_lat_ch", max_ch, 0);
        rst_n = 1'b1;

        // ch3: request, pop at cycle 5
        for (int i = 0; i < 5; i++) add(16'h0008, 0, 40'h12, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        add(16'h0008, 16'h0008, 40'h12, 0, 0, 0, 0, 0, 5, 3, 3, 1, 0);
        add(0, 0, 40'h12, 0, 0, 0, 0, 0, 5, 3, 3, 1, 0);
        // ch7: pop with no pending ever seen
        add(0, 16'h0080, 40'h12, 0, 16'h0080, 0, 0, 0, 5, 3, 7, 0, 0);
        // ch9: zero-wait pop, then legal trailing pop (not counted)
        add(16'h0200, 16'h0200, 40'h12, 0, 16'h0080, 0, 0, 0, 5, 3, 9, 1, 1);
        add(0, 16'h0200, 40'h12, 0, 16'h0080, 0, 0, 0, 5, 3, 9, 1, 1);
        // ch2: withdraw after 3 cycles
        for (int i = 0; i < 3; i++) add(16'h0004, 0, 40'h12, 0, 16'h0080, 0, 0, 0, 5, 3, 2, 0, 1);
        add(0, 0, 40'h12, 0, 16'h0080, 0, 16'h0004, 0, 5, 3, 2, 0, 1);
        // ch2: data changes while waiting, then pop at latency 2
        add(16'h0004, 0, 40'h12, 0, 16'h0080, 0, 16'h0004, 0, 5, 3, 2, 0, 1);
        add(16'h0004, 0, 40'h13, 0, 16'h0080, 0, 16'h0004, 16'h0004, 5, 3, 2, 0, 1);
        add(16'h0004, 16'h0004, 40'h13, 0, 16'h0080, 0, 16'h0004, 16'h0004, 5, 3, 2, 1, 1);
        // ch1 and ch4 both complete at latency 9 in the same cycle
        for (int i = 0; i < 9; i++)
            add(16'h0012, 0, 40'h12, 0, 16'h0080, 0, 16'h0004, 16'h0004, 5, 3, 1, 0, 1);
        add(16'h0012, 16'h0012, 40'h12, 0, 16'h0080, 0, 16'h0004, 16'h0004, 9, 1, 1, 1, 1);
        add(0, 0, 40'h12, 0, 16'h0080, 0, 16'h0004, 16'h0004, 9, 1, 4, 1, 1);
        // clr together with an illegal pop on ch5
        add(0, 16'h0020, 40'h12, 1, 16'h0020, 0, 0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 40'h12, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 40'h12, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].pndng, vecs[i].pop, vecs[i].data, vecs[i].clr);
            chk($sformatf("v%0d err_pop", i), err_pop, vecs[i].epop);
            chk($sformatf("v%0d err_timeout", i), err_to, vecs[i].eto);
            chk($sformatf("v%0d err_withdraw", i), err_wd, vecs[i].ewd);
            chk($sformatf("v%0d err_data", i), err_data, vecs[i].edata);
            chk($sformatf("v%0d max_lat", i), max_lat, vecs[i].emax);
            chk($sformatf("v%0d max_lat_ch", i), max_ch, vecs[i].ech);
            chk($sformatf("v%0d txn_cnt[%0d]", i, vecs[i].cch), cnt_of(vecs[i].cch), vecs[i].ecnt);
            chk($sformatf("v%0d err_any", i), err_any, vecs[i].eany);
        end

        // ch0 times out and pops late at cycle 120; ch11 pops exactly at MAX_LAT
        for (int k = 0; k <= 120; k++) begin
            pn = 16'h0001 | ((k <= MLAT) ? 16'h0800 : 16'h0000);
            po = ((k == MLAT) ? 16'h0800 : 16'h0000) | ((k == 120) ? 16'h0001 : 16'h0000);
            step(pn, po, 40'h12, 0);
            if (k == MLAT - 1) chk("to k99 err_timeout", err_to, 0);
            if (k == MLAT) begin
                chk("to k100 err_timeout", err_to, 16'h0001);
                chk("to k100 max_lat", max_lat, 100);
                chk("to k100 max_lat_ch", max_ch, 11);
                chk("to k100 txn_cnt[11]", cnt_of(11), 1);
            end
            if (k == 119) chk("to k119 txn_cnt[0]", cnt_of(0), 0);
            if (k == 120) begin
                chk("to k120 err_timeout", err_to, 16'h0001);
                chk("to k120 err_withdraw", err_wd, 0);
                chk("to k120 max_lat", max_lat, 101);
                chk("to k120 max_lat_ch", max_ch, 0);
                chk("to k120 txn_cnt[0]", cnt_of(0), 1);
            end
        end
        step(0, 0, 40'h12, 0);
        chk("to err_any", err_any, 1);

        // ch6 waits 50 cycles, then reset hits mid-wait
        for (int k = 0; k < 50; k++) step(16'h0040, 0, 40'h12, 0);
        chk("pre-rst err_timeout", err_to, 16'h0001);
        #2 rst_n = 1'b0;
        pndng = '0;
        #1;
        chk("async rst txn_cnt[0]", cnt_of(0), 0);
        chk("async rst err_timeout", err_to, 0);
        chk("async rst max_lat", max_lat, 0);
        chk("async rst err_any", err_any, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // first sample after reset: ch6 zero-wait, ch12 pop with no prior pndng
        step(16'h0040, 16'h1040, 40'h12, 0);
        chk("post-rst txn_cnt[6]", cnt_of(6), 1);
        chk("post-rst max_lat", max_lat, 0);
        chk("post-rst max_lat_ch", max_ch, 0);
        chk("post-rst err_pop", err_pop, 16'h1000);
        for (int k = 0; k < 110; k++) step(0, 0, 40'h12, 0);
        chk("post-rst err_timeout", err_to, 0);
        chk("post-rst err_withdraw", err_wd, 0);
        chk("post-rst txn_cnt[6] hold", cnt_of(6), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
